// File: rtl/pc_seq_pkg.sv
// Shared encodings for the LEGv8 PC sequencer: FSM states, branch types, PC function selects.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_UPDATE = 3'd2,
    ST_HALT   = 3'd3
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    ST_FAULT  = 3'd4
`endif
  } state_t;

  localparam logic [2:0] BR_NONE  = 3'b000;
  localparam logic [2:0] BR_B     = 3'b001;
  localparam logic [2:0] BR_CBZ   = 3'b010;
  localparam logic [2:0] BR_CBNZ  = 3'b011;
  localparam logic [2:0] BR_BR    = 3'b100;
  localparam logic [2:0] BR_BCOND = 3'b101;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch decision: branch type plus flags to a ProgramCounter function select.
module branch_resolve
  import pc_seq_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       cond_true,
  output logic [1:0] ps_code
);

  always_comb begin
    ps_code = PS_INC;
    case (br_type)
      BR_NONE:  ps_code = PS_INC;
      BR_B:     ps_code = PS_REL;
      BR_CBZ:   ps_code = zero ? PS_REL : PS_INC;
      BR_CBNZ:  ps_code = zero ? PS_INC : PS_REL;
      BR_BR:    ps_code = PS_LOAD;
      BR_BCOND: ps_code = cond_true ? PS_REL : PS_INC;
      default:  ps_code = PS_INC;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/UPDATE controller for the LEGv8 ProgramCounter; counts retired instructions.
// Optional BR alignment fault state enabled by PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N        = 64,
  parameter int WAIT_MAX = 15
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  input  logic          imem_ack,
  output logic          ir_load,
  input  logic [2:0]    br_type,
  input  logic          zero,
  input  logic          cond_true,
  input  logic [N-1:0]  target,
  input  logic          stall,
  input  logic          halt,
  output logic [1:0]    PS,
  output logic [N-1:0]  pc_in,
  output logic          halted,
  output logic          timeout,
  output logic          fault,
  output logic [31:0]   retired
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t        state_q, state_d;
  logic [1:0]    ps_q;
  logic [N-1:0]  pc_q;
  logic [CW-1:0] wait_cnt;
  logic          halted_q, timeout_q;
  logic [1:0]    br_ps;
  logic          dec_go, wait_inc, to_timeout;

  branch_resolve u_branch_resolve (
    .br_type   (br_type),
    .zero      (zero),
    .cond_true (cond_true),
    .ps_code   (br_ps)
  );

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misaligned;
  logic fault_q;
  assign misaligned = (br_type == BR_BR) && (target[1:0] != 2'b00);
  assign fault      = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dec_go     = 1'b0;
    wait_inc   = 1'b0;
    to_timeout = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
          to_timeout = 1'b1;
          state_d    = ST_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          dec_go  = 1'b1;
          state_d = ST_UPDATE;
`ifdef PC_SEQ_ALIGN_CHECK_EN
          if (misaligned) begin
            dec_go  = 1'b0;
            state_d = ST_FAULT;
          end
`endif
        end
      end
      ST_UPDATE: state_d = halt ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      ST_FAULT:  state_d = ST_FAULT;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  // ps_q is loaded only on the DECODE->UPDATE edge, so PS is non-hold for exactly the UPDATE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q      <= PS_HOLD;
      pc_q      <= '0;
      wait_cnt  <= '0;
      retired   <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      ps_q <= dec_go ? br_ps : PS_HOLD;
      if (dec_go) pc_q <= target;
      if (wait_inc)                   wait_cnt <= wait_cnt + CW'(1);
      else if (state_q == ST_UPDATE)  wait_cnt <= '0;
      if (state_q == ST_UPDATE) retired <= retired + 32'd1;
      if (state_d == ST_HALT)   halted_q  <= 1'b1;
      if (to_timeout)           timeout_q <= 1'b1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      if (state_d == ST_FAULT)  fault_q   <= 1'b1;
`endif
    end
  end

  assign PS      = ps_q;
  assign pc_in   = pc_q;
  assign halted  = halted_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        ir_load;
  logic [2:0]  br_type = 3'b000;
  logic        zero = 1'b0;
  logic        cond_true = 1'b0;
  logic [63:0] target = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  ps;
  logic [63:0] pc_in;
  logic        halted;
  logic        timeout;
  logic        fault;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.N(64), .WAIT_MAX(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .ir_load   (ir_load),
    .br_type   (br_type),
    .zero      (zero),
    .cond_true (cond_true),
    .target    (target),
    .stall     (stall),
    .halt      (halt),
    .PS        (ps),
    .pc_in     (pc_in),
    .halted    (halted),
    .timeout   (timeout),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in the first post-reset FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    stall = 1'b0;
    halt = 1'b0;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // From a FETCH cycle: ack, hold DECODE for nstall cycles, return in the UPDATE cycle.
  task automatic fetch_decode(input logic [2:0] bt, input logic z, input logic ct,
                              input logic [63:0] tgt, input int nstall);
    br_type = bt;
    zero = z;
    cond_true = ct;
    target = tgt;
    imem_ack = 1'b1;
    nxt();
    imem_ack = 1'b0;
    stall = (nstall > 0);
    for (int i = 0; i < nstall; i++) begin
      #1;
      chk("stall_ps", 64'(ps), 64'd0);
      nxt();
      if (i == nstall - 1) stall = 1'b0;
    end
    #1;
    chk("decode_ps", 64'(ps), 64'd0);
    nxt();
  endtask

  logic [2:0]  v_bt [6]  = '{3'b010, 3'b011, 3'b101, 3'b101, 3'b001, 3'b111};
  logic        v_z  [6]  = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
  logic        v_ct [6]  = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
  logic [1:0]  v_ps [6]  = '{2'b01,  2'b11,  2'b11,  2'b01,  2'b11,  2'b01};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ret;

    // Reset values and first instruction timing
    do_reset();
    chk("rst_imem_req", 64'(imem_req), 64'd1);
    chk("rst_ps", 64'(ps), 64'd0);
    chk("rst_pc_in", pc_in, 64'd0);
    chk("rst_ir_load", 64'(ir_load), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    br_type = 3'b000;
    imem_ack = 1'b1;
    #1;
    chk("c1_ir_load", 64'(ir_load), 64'd1);
    nxt();
    imem_ack = 1'b0;
    #1;
    chk("c2_ps", 64'(ps), 64'd0);
    chk("c2_imem_req", 64'(imem_req), 64'd0);
    chk("c2_ir_load", 64'(ir_load), 64'd0);
    nxt();
    chk("c3_ps", 64'(ps), 64'd1);
    nxt();
    chk("c4_ps", 64'(ps), 64'd0);
    chk("c4_imem_req", 64'(imem_req), 64'd1);
    chk("c4_retired", 64'(retired), 64'd1);
    exp_ret = 1;

    // CBZ taken / not taken
    fetch_decode(3'b010, 1'b1, 1'b0, 64'd5, 0);
    chk("cbz_z1_ps", 64'(ps), 64'd3);
    chk("cbz_z1_pc_in", pc_in, 64'd5);
    nxt();
    exp_ret++;
    fetch_decode(3'b010, 1'b0, 1'b0, 64'd5, 0);
    chk("cbz_z0_ps", 64'(ps), 64'd1);
    nxt();
    exp_ret++;

    // Remaining branch kinds
    for (int i = 0; i < 6; i++) begin
      fetch_decode(v_bt[i], v_z[i], v_ct[i], 64'(i + 8), 0);
      chk($sformatf("vec%0d_ps", i), 64'(ps), 64'(v_ps[i]));
      chk($sformatf("vec%0d_pc_in", i), pc_in, 64'(i + 8));
      nxt();
      exp_ret++;
    end
    chk("vec_retired", 64'(retired), 64'(exp_ret));

    // BR with two stall cycles
    fetch_decode(3'b100, 1'b0, 1'b0, 64'h1000, 2);
    chk("br_stall_ps", 64'(ps), 64'd2);
    chk("br_stall_pc_in", pc_in, 64'h1000);
    nxt();
    exp_ret++;
    chk("br_stall_after_ps", 64'(ps), 64'd0);
    chk("br_stall_retired", 64'(retired), 64'(exp_ret));

    // halt sampled in UPDATE; later acks ignored
    fetch_decode(3'b000, 1'b0, 1'b0, 64'd0, 0);
    halt = 1'b1;
    nxt();
    halt = 1'b0;
    exp_ret++;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_imem_req", 64'(imem_req), 64'd0);
    chk("halt_ps", 64'(ps), 64'd0);
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    chk("halt_ack_ir_load", 64'(ir_load), 64'd0);
    imem_ack = 1'b0;
    chk("halt_hold", 64'(halted), 64'd1);
    chk("halt_retired", 64'(retired), 64'(exp_ret));

    // Fetch timeout after 15 cycles without ack
    do_reset();
    for (int i = 0; i < 14; i++) nxt();
    chk("to_c15_timeout", 64'(timeout), 64'd0);
    chk("to_c15_imem_req", 64'(imem_req), 64'd1);
    nxt();
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_imem_req", 64'(imem_req), 64'd0);

    // Ack on the 15th cycle wins
    do_reset();
    for (int i = 0; i < 14; i++) nxt();
    br_type = 3'b000;
    imem_ack = 1'b1;
    nxt();
    imem_ack = 1'b0;
    chk("ack15_timeout", 64'(timeout), 64'd0);
    chk("ack15_halted", 64'(halted), 64'd0);
    nxt();
    chk("ack15_ps", 64'(ps), 64'd1);
    nxt();
    chk("ack15_retired", 64'(retired), 64'd1);
    chk("ack15_imem_req", 64'(imem_req), 64'd1);

    // Reset during UPDATE
    fetch_decode(3'b001, 1'b0, 1'b0, 64'd3, 0);
    chk("mid_upd_ps", 64'(ps), 64'd3);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk("mid_rst_retired", 64'(retired), 64'd0);
    chk("mid_rst_imem_req", 64'(imem_req), 64'd1);
    chk("mid_rst_ps", 64'(ps), 64'd0);
    chk("mid_rst_halted", 64'(halted), 64'd0);

    // Misaligned BR target
    do_reset();
    fetch_decode(3'b100, 1'b0, 1'b0, 64'h1002, 0);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    chk("al_fault", 64'(fault), 64'd1);
    chk("al_ps", 64'(ps), 64'd0);
    nxt();
    chk("al_retired", 64'(retired), 64'd0);
    chk("al_imem_req", 64'(imem_req), 64'd0);
`else
    chk("al_ps", 64'(ps), 64'd2);
    chk("al_pc_in", pc_in, 64'h1002);
    chk("al_fault", 64'(fault), 64'd0);
    nxt();
    chk("al_retired", 64'(retired), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
